// File: rtl/video_layer_mixer.sv
// video_layer_mixer
// Picks one of NUM_SRC full-frame RGB sources and crossfades through black
// whenever the selection changes. Fade steps advance on frame_start pulses.
// An unscaled overlay and a blank override sit on top of the faded pixel.
// The pixel and status outputs are registered; sync timing is not touched here.
module video_layer_mixer #(
    parameter  int NUM_SRC         = 3,
    parameter  int COLOR_W         = 4,
    parameter  int FADE_STEPS      = 8,
    parameter  int FRAMES_PER_STEP = 2,
    localparam int SEL_W           = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int LVL_W           = $clog2(FADE_STEPS) + 1
) (
    input  logic                         clk,
    input  logic                         reset_out,
    input  logic [SEL_W-1:0]             src_sel,
    input  logic [NUM_SRC*3*COLOR_W-1:0] src_rgb,
    input  logic                         overlay_en,
    input  logic [3*COLOR_W-1:0]         overlay_rgb,
    input  logic                         frame_start,
    input  logic                         blank,
    output logic [COLOR_W-1:0]           r,
    output logic [COLOR_W-1:0]           g,
    output logic [COLOR_W-1:0]           b,
    output logic                         fading,
    output logic [SEL_W-1:0]             active_src
);

    typedef enum logic [1:0] {
        SHOW     = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } state_t;

    localparam int              SHIFT     = $clog2(FADE_STEPS);
    localparam int              PROD_W    = COLOR_W + LVL_W;
    localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(FADE_STEPS);
    localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [3:0]      FCNT_LAST = 4'(FRAMES_PER_STEP - 1);
    localparam logic [31:0]     NUM_SRC_C = 32'(NUM_SRC);

    // Channel brightness scaling: (c * lvl) >> log2(FADE_STEPS), truncating.
    function automatic logic [COLOR_W-1:0] scale_chan(
        input logic [COLOR_W-1:0] c,
        input logic [LVL_W-1:0]   l
    );
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(c) * PROD_W'(l);
        return COLOR_W'(prod >> SHIFT);
    endfunction

    state_t               state_r, state_nx_s;
    logic [LVL_W-1:0]     lvl_r, lvl_nx_s, lvl_inc_s;
    logic [3:0]           fcnt_r, fcnt_nx_s;
    logic [SEL_W-1:0]     pend_r, pend_nx_s;
    logic [SEL_W-1:0]     active_r, active_nx_s;
    logic                 sel_in_range_s;
    logic                 req_valid_s;
    logic                 tick_s;
    logic [3*COLOR_W-1:0] src_pix_s;
    logic [3*COLOR_W-1:0] pix_nx_s;
    logic [COLOR_W-1:0]   r_r, g_r, b_r;
    logic                 fading_r;

    // Request qualification and fade step tick.
    always_comb begin
        sel_in_range_s = ({{(32-SEL_W){1'b0}}, src_sel} < NUM_SRC_C);
        req_valid_s    = sel_in_range_s && (src_sel != active_r);
        tick_s         = frame_start && (fcnt_r == FCNT_LAST);
        lvl_inc_s      = lvl_r + LVL_ONE;
    end

    // Fade FSM next-state, level, frame counter and source bookkeeping.
    always_comb begin
        state_nx_s  = state_r;
        lvl_nx_s    = lvl_r;
        fcnt_nx_s   = fcnt_r;
        pend_nx_s   = pend_r;
        active_nx_s = active_r;
        case (state_r)
            SHOW: begin
                lvl_nx_s  = LVL_MAX;
                fcnt_nx_s = 4'd0;
                if (req_valid_s) begin
                    pend_nx_s  = src_sel;
                    state_nx_s = FADE_OUT;
                end else begin
                    state_nx_s = SHOW;
                end
            end
            FADE_OUT: begin
                if (sel_in_range_s) begin
                    pend_nx_s = src_sel;
                end else begin
                    pend_nx_s = pend_r;
                end
                if (tick_s) begin
                    fcnt_nx_s = 4'd0;
                    // A reversal taken at level 0 still needs one tick here
                    // before the swap, so clamp instead of wrapping.
                    if (lvl_r <= LVL_ONE) begin
                        lvl_nx_s    = LVL_ZERO;
                        active_nx_s = pend_r;
                        state_nx_s  = FADE_IN;
                    end else begin
                        lvl_nx_s = lvl_r - LVL_ONE;
                    end
                end else if (frame_start) begin
                    fcnt_nx_s = fcnt_r + 4'd1;
                end else begin
                    fcnt_nx_s = fcnt_r;
                end
            end
            FADE_IN: begin
                // A new request reverses the fade and wins over a same-cycle tick.
                if (req_valid_s) begin
                    pend_nx_s  = src_sel;
                    fcnt_nx_s  = 4'd0;
                    state_nx_s = FADE_OUT;
                end else if (tick_s) begin
                    fcnt_nx_s = 4'd0;
                    lvl_nx_s  = lvl_inc_s;
                    if (lvl_inc_s >= LVL_MAX) begin
                        state_nx_s = SHOW;
                    end else begin
                        state_nx_s = FADE_IN;
                    end
                end else if (frame_start) begin
                    fcnt_nx_s = fcnt_r + 4'd1;
                end else begin
                    fcnt_nx_s = fcnt_r;
                end
            end
            default: begin
                state_nx_s = SHOW;
                lvl_nx_s   = LVL_MAX;
                fcnt_nx_s  = 4'd0;
            end
        endcase
    end

    // Source mux for the currently active source.
    always_comb begin
        src_pix_s = src_rgb[3*COLOR_W-1:0];
        for (int k = 0; k < NUM_SRC; k++) begin
            src_pix_s = (active_r == SEL_W'(k)) ? src_rgb[k*3*COLOR_W +: 3*COLOR_W] : src_pix_s;
        end
    end

    // Pixel priority: blank, then overlay, then faded source.
    always_comb begin
        pix_nx_s = {(3*COLOR_W){1'b0}};
        if (blank) begin
            pix_nx_s = {(3*COLOR_W){1'b0}};
        end else if (overlay_en) begin
            pix_nx_s = overlay_rgb;
        end else begin
            pix_nx_s = {scale_chan(src_pix_s[3*COLOR_W-1:2*COLOR_W], lvl_r),
                        scale_chan(src_pix_s[2*COLOR_W-1:COLOR_W],   lvl_r),
                        scale_chan(src_pix_s[COLOR_W-1:0],           lvl_r)};
        end
    end

    // State, level, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset_out) begin
            state_r  <= SHOW;
            lvl_r    <= LVL_MAX;
            fcnt_r   <= 4'd0;
            pend_r   <= {SEL_W{1'b0}};
            active_r <= {SEL_W{1'b0}};
            r_r      <= {COLOR_W{1'b0}};
            g_r      <= {COLOR_W{1'b0}};
            b_r      <= {COLOR_W{1'b0}};
            fading_r <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            lvl_r    <= lvl_nx_s;
            fcnt_r   <= fcnt_nx_s;
            pend_r   <= pend_nx_s;
            active_r <= active_nx_s;
            r_r      <= pix_nx_s[3*COLOR_W-1:2*COLOR_W];
            g_r      <= pix_nx_s[2*COLOR_W-1:COLOR_W];
            b_r      <= pix_nx_s[COLOR_W-1:0];
            fading_r <= (state_nx_s != SHOW);
        end
    end

    assign r          = r_r;
    assign g          = g_r;
    assign b          = b_r;
    assign fading     = fading_r;
    assign active_src = active_r;

endmodule
